// File: rtl/mdu_sequencer_pkg.sv
// rtl/mdu_sequencer_pkg.sv - shared MD op codes, FSM states, latency defaults and result type
// Purpose: common definitions for the multiply/divide sequencer, its calculator and interface.
// Ports: none (package).
package mdu_sequencer_pkg;

   localparam int DATA_W          = 32;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   localparam int CNT_W           = 8;

   typedef enum logic [3:0] {
      MD_MULT  = 4'b0000,
      MD_MULTU = 4'b0001,
      MD_DIV   = 4'b0010,
      MD_DIVU  = 4'b0011,
      MD_MFHI  = 4'b0100,
      MD_MFLO  = 4'b0101,
      MD_MTHI  = 4'b0110,
      MD_MTLO  = 4'b0111,
      MD_NONE  = 4'b1111
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic              div0;
   } md_res_t;

   // Only the four arithmetic ops (codes 00xx) may launch a sequenced operation.
   function automatic logic is_calc_op(input logic [3:0] op);
      return op[3:2] == 2'b00;
   endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - E-stage control to MDU handshake bundle
// Purpose: groups the MD request, operands and status/result signals.
// Ports (master = E-stage control / hazard side, slave = MDU):
//   start, md_op, rs_val, rt_val, d_uses_md : master -> slave
//   busy, md_rd, stall_req                  : slave -> master
interface mdu_sequencer_if;
   import mdu_sequencer_pkg::*;

   logic              start;
   logic [3:0]        md_op;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic              d_uses_md;
   logic              busy;
   logic [DATA_W-1:0] md_rd;
   logic              stall_req;

   modport master (
      output start, md_op, rs_val, rt_val, d_uses_md,
      input  busy, md_rd, stall_req
   );

   modport slave (
      input  start, md_op, rs_val, rt_val, d_uses_md,
      output busy, md_rd, stall_req
   );

endinterface

// File: rtl/mdu_sequencer_calc.sv
// rtl/mdu_sequencer_calc.sv - combinational mult/multu/div/divu result generator
// Purpose: produces {hi,lo} for the arithmetic op selected by op_i plus a divide-by-zero flag.
// Ports: op_i[1:0] (00 mult, 01 multu, 10 div, 11 divu), rs_i, rt_i operands; res_o result struct.
module mdu_sequencer_calc
   import mdu_sequencer_pkg::*;
(
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] rs_i,
   input  logic [DATA_W-1:0] rt_i,
   output md_res_t           res_o
);

   logic signed [63:0]       smul;
   logic        [63:0]       umul;
   logic        [DATA_W-1:0] divisor;
   logic signed [DATA_W-1:0] squot;
   logic signed [DATA_W-1:0] srem;
   logic        [DATA_W-1:0] uquot;
   logic        [DATA_W-1:0] urem;
   logic                     rt_zero;

   assign rt_zero = (rt_i == '0);
   // A zero divisor is replaced by 1 so the dividers never produce X; the
   // sequencer discards the result anyway when div0 is set.
   assign divisor = rt_zero ? 32'd1 : rt_i;

   assign smul  = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
   assign umul  = {32'b0, rs_i} * {32'b0, rt_i};
   // SV signed / and % truncate toward zero, remainder follows the dividend.
   assign squot = $signed(rs_i) / $signed(divisor);
   assign srem  = $signed(rs_i) % $signed(divisor);
   assign uquot = rs_i / divisor;
   assign urem  = rs_i % divisor;

   always_comb begin
      res_o      = '0;
      res_o.div0 = op_i[1] & rt_zero;
      unique case (op_i)
         2'b00: {res_o.hi, res_o.lo} = smul;
         2'b01: {res_o.hi, res_o.lo} = umul;
         2'b10: begin
            res_o.hi = srem;
            res_o.lo = squot;
         end
         default: begin
            res_o.hi = urem;
            res_o.lo = uquot;
         end
      endcase
   end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle multiply/divide sequencer owning HI/LO
// Purpose: launches mult/div on start, counts down the modelled latency, commits HI/LO,
//          serves mfhi/mflo/mthi/mtlo and requests D-stage stalls.
// Ports: clk, reset (sync, active-high); md (slave modport): start, md_op, rs_val, rt_val,
//        d_uses_md in; busy, md_rd, stall_req out.
module mdu_sequencer
   import mdu_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            reset,
   mdu_sequencer_if.slave  md
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
   logic [DATA_W-1:0] pend_lo_q, pend_lo_d;
   logic              pend_wr_q, pend_wr_d;
   md_res_t           calc_res;

   mdu_sequencer_calc u_calc (
      .op_i  (md.md_op[1:0]),
      .rs_i  (md.rs_val),
      .rt_i  (md.rt_val),
      .res_o (calc_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (md.start && is_calc_op(md.md_op)) begin
               state_d   = ST_RUN;
               cnt_d     = md.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               pend_hi_d = calc_res.hi;
               pend_lo_d = calc_res.lo;
               // Divide by zero still burns the full latency but must not commit.
               pend_wr_d = ~calc_res.div0;
            end else if (md.md_op == MD_MTHI) begin
               hi_d = md.rs_val;
            end else if (md.md_op == MD_MTLO) begin
               lo_d = md.rs_val;
            end
         end
         default: begin
            // Starts and moves arriving while running are deliberately ignored.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   always_comb begin
      md.busy = (state_q == ST_RUN);
      // Including start covers the launch cycle before busy has risen.
      md.stall_req = md.d_uses_md & (md.start | md.busy);
      if (md.md_op == MD_MFHI) begin
         md.md_rd = hi_q;
      end else if (md.md_op == MD_MFLO) begin
         md.md_rd = lo_q;
      end else begin
         md.md_rd = '0;
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - self-checking bench for mdu_sequencer
module tb_mdu_sequencer;
   import mdu_sequencer_pkg::*;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          cycles;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t vecs[9];

   mdu_sequencer_if bus ();

   mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      bus.md_op = MD_MFHI;
      #1 hi = bus.md_rd;
      bus.md_op = MD_MFLO;
      #1 lo = bus.md_rd;
      bus.md_op = MD_NONE;
   endtask

   task automatic move_to(input logic [3:0] op, input logic [31:0] val);
      bus.md_op  = op;
      bus.rs_val = val;
      next_cycle();
      bus.md_op  = MD_NONE;
   endtask

   // poke: 0 none, 1 mthi during busy cycle 2, 2 start div during busy cycle 2
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int cycles, input int poke);
      exp_t        e;
      exp_t        got;
      int          cnt;
      bus.start  = 1'b1;
      bus.md_op  = op;
      bus.rs_val = rs;
      bus.rt_val = rt;
      e.hi = exp_hi;
      e.lo = exp_lo;
      sb.push_back(e);
      next_cycle();
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 64) begin
         cnt++;
         if (poke == 1 && cnt == 2) begin
            bus.md_op  = MD_MTHI;
            bus.rs_val = 32'hDEAD_BEEF;
         end else if (poke == 2 && cnt == 2) begin
            bus.start  = 1'b1;
            bus.md_op  = MD_DIV;
            bus.rs_val = 32'd100;
            bus.rt_val = 32'd7;
         end else begin
            bus.start = 1'b0;
            bus.md_op = MD_NONE;
         end
         next_cycle();
      end
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      check({name, "_busy_cycles"}, 32'(cnt), 32'(cycles));
      read_hilo(got.hi, got.lo);
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({name, "_hi"}, got.hi, e.hi);
         check({name, "_lo"}, got.lo, e.lo);
      end
      next_cycle();
   endtask

   initial begin
      logic [31:0] h;
      logic [31:0] l;

      vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
      vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
      vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[3] = '{MD_DIVU,  32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 10};
      vecs[4] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
      vecs[5] = '{MD_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
      vecs[6] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd10,       32'h0000_0005, 32'h1999_9999, 10};
      vecs[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
      vecs[8] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};

      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.md_op      = MD_NONE;
      bus.rs_val     = '0;
      bus.rt_val     = '0;
      bus.d_uses_md  = 1'b0;
      repeat (3) next_cycle();
      reset = 1'b0;

      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_stall", 32'(bus.stall_req), 32'd0);
      read_hilo(h, l);
      check("rst_hi", h, 32'd0);
      check("rst_lo", l, 32'd0);
      next_cycle();

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cycles, 0);
      end

      // Divide by zero keeps the values written by mthi/mtlo.
      move_to(MD_MTHI, 32'h11);
      move_to(MD_MTLO, 32'h22);
      run_op("div0", MD_DIVU, 32'd7, 32'd0, 32'h11, 32'h22, 10, 0);

      // Moves and starts during busy are ignored.
      run_op("mthi_busy", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1);
      run_op("start_busy", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 5, 2);

      // Undefined op has no effect and reads as zero.
      bus.md_op  = 4'b1000;
      bus.rs_val = 32'h99;
      #1 check("undef_rd", bus.md_rd, 32'd0);
      next_cycle();
      bus.md_op = MD_NONE;
      read_hilo(h, l);
      check("undef_hi", h, 32'd0);
      check("undef_lo", l, 32'd42);
      next_cycle();

      // Stall request across a mult with the D-stage MD op held.
      bus.d_uses_md = 1'b1;
      bus.start     = 1'b1;
      bus.md_op     = MD_MULT;
      bus.rs_val    = 32'd2;
      bus.rt_val    = 32'd2;
      #1 check("stall_start", 32'(bus.stall_req), 32'd1);
      next_cycle();
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      for (int i = 0; i < 5; i++) begin
         #1 check($sformatf("stall_busy%0d", i), 32'({bus.busy, bus.stall_req}), 32'd3);
         next_cycle();
      end
      #1 check("stall_done", 32'({bus.busy, bus.stall_req}), 32'd0);
      bus.d_uses_md = 1'b0;
      next_cycle();

      // Reset in the middle of a divide discards everything.
      move_to(MD_MTHI, 32'h55);
      bus.start  = 1'b1;
      bus.md_op  = MD_DIV;
      bus.rs_val = 32'd100;
      bus.rt_val = 32'd3;
      next_cycle();
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      next_cycle();
      next_cycle();
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      read_hilo(h, l);
      check("midrst_hi", h, 32'd0);
      check("midrst_lo", l, 32'd0);
      repeat (12) next_cycle();
      read_hilo(h, l);
      check("midrst_late_hi", h, 32'd0);
      check("midrst_late_lo", l, 32'd0);
      next_cycle();

      run_op("post_rst", MD_DIV, 32'd100, 32'd3, 32'd1, 32'd33, 10, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
